angle_force_accumulator: RTL and testbench
==========================================

Name: angle_force_accumulator

Overview:
- Downstream of the angle-force stage: consumes one angle's force triplet (atoms A, B vertex, C) per transaction.
- Adds each force into a per-atom Q16.16 force register file using read-modify-write (RMW).
- The integrator/readout reads the file afterwards. A sweep-clear zeroes it between timesteps.

Parameters:
- ATOM_ADDR_W, 6, atom index width; the file holds 2**ATOM_ADDR_W atoms.
- DATA_W, 32, force component width, signed Q16.16.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  pulse; starts the zeroing sweep of the whole file
- in_valid  in  1  force triplet available
- in_ready  out  1  block accepts a triplet this cycle
- idx_a, idx_b, idx_c  in  ATOM_ADDR_W each  atom indices for end atom A, vertex B, end atom C
- fax, fay, faz  in  DATA_W each  force on A
- fbx, fby, fbz  in  DATA_W each  force on B
- fcx, fcy, fcz  in  DATA_W each  force on C
- rd_en  in  1  read request
- rd_idx  in  ATOM_ADDR_W  atom to read
- rd_fx, rd_fy, rd_fz  out  DATA_W each  read data
- rd_valid  out  1  read data valid
- busy  out  1  RMW or clear in progress
- sat_flag  out  1  sticky: an accumulation saturated

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - All file entries = 0.
  - State = S_IDLE; busy = 0; sat_flag = 0.
  - rd_valid = 0; rd_fx/fy/fz = 0; clear counter = 0.
- Reset asserted mid-RMW or mid-clear abandons the operation immediately. Partial updates are lost and the file reads 0.
- States: S_IDLE, S_ACC_A, S_ACC_B, S_ACC_C, S_CLEAR.
- in_ready = (state == S_IDLE) && !clear. It is combinational.
- Accept = in_valid && in_ready. On accept:
  - Latch all 3 indices and all 9 components into holding registers.
  - Go to S_ACC_A; busy = 1 from the next cycle.
  - Inputs may change after the accept cycle.
- RMW sequence (one atom per cycle, updating x, y and z together):
  - S_ACC_A: file[idx_a] += fa; go to S_ACC_B.
  - S_ACC_B: file[idx_b] += fb; go to S_ACC_C.
  - S_ACC_C: file[idx_c] += fc; go to S_IDLE; busy = 0.
  - Throughput is 1 triplet per 4 cycles. Next accept is possible the cycle after S_ACC_C.
- Aliased indices (idx_a == idx_c, etc.) are correct by construction: each step reads the value written by the previous step.
- Addition: 33-bit signed sum, then narrowed to DATA_W (see FACC_SAT_EN).
- Clear:
  - clear sampled in S_IDLE starts the sweep. clear has priority over in_valid in the same cycle; in_ready is 0 that cycle.
  - S_CLEAR zeroes entry cnt each cycle, cnt = 0 .. 2**ATOM_ADDR_W-1. That is 2**ATOM_ADDR_W cycles, busy = 1 throughout.
  - Returns to S_IDLE after the last entry; cnt wraps to 0.
  - sat_flag is cleared on entry to S_CLEAR.
  - clear asserted outside S_IDLE is ignored. It is not queued.
- Read port:
  - Operates in any state. rd_en in cycle N gives rd_f* = file[rd_idx] and rd_valid = 1 in cycle N+1.
  - rd_valid = 0 when rd_en was 0. rd_f* hold their last value.
  - A read of an entry being written in the same cycle returns the pre-write value.

Optional Feature:
- Macro: FACC_SAT_EN.
- Defined:
  - A 33-bit sum above 0x7FFFFFFF clamps to 0x7FFFFFFF; below -0x80000000 clamps to 0x80000000.
  - Clamping is per component and sets sat_flag (sticky until clear or reset).
- Undefined:
  - Sum truncated to DATA_W with two's-complement wrap.
  - sat_flag tied 0.

Test Plan:
- Reset, then rd_en at idx 5 -> rd_valid next cycle, rd_fx/fy/fz = 0; in_ready = 1; busy = 0.
- One accept with idx a=1/b=2/c=3, fa = (0x00010000,0,0), fb = (0xFFFE0000,0,0), fc = (0x00010000,0,0):
  - busy for 3 cycles, in_ready low for 3 cycles.
  - Reads give atom1 x=0x00010000, atom2 x=0xFFFE0000, atom3 x=0x00010000.
- Aliasing: a=c=4, fa.y = fc.y = 0x00008000, fb = 0 -> atom4 y = 0x00010000.
- Repeat the same triplet twice back-to-back, with in_valid held high -> second accept 4 cycles after the first; each entry holds double the value.
- Overflow: atom 7 x = 0x7FFF0000, then add 0x00020000:
  - With FACC_SAT_EN: 0x7FFFFFFF, sat_flag = 1.
  - Without it: 0x80010000, sat_flag = 0.
- clear and in_valid asserted together in S_IDLE -> in_ready = 0; 2**ATOM_ADDR_W (64) cycles of busy; all entries read 0; sat_flag = 0; the triplet is then accepted.

Source files
------------

// File: rtl/angle_force_accumulator.sv
// -----------------------------------------------------------------------------
// angle_force_accumulator
//
// Purpose:
//   Accumulates one angle's force triplet (end atom A, vertex atom B, end atom
//   C) per transaction into a per-atom Q16.16 force register file. Each atom
//   is updated by read-modify-write, one atom per cycle, in the order A, B, C.
//   So aliased indices naturally see the previous step's result. A clear pulse
//   sweeps the whole file to zero, one entry per cycle. An independent read
//   port returns an entry one cycle after the request.
//
// Configuration:
//   FACC_SAT_EN - when defined, each component sum saturates to the Q16.16
//                 range and sets the sticky sat_flag. When undefined, sums
//                 wrap in two's complement and sat_flag is tied low.
//
// Ports:
//   clk                 system clock
//   rst_n               asynchronous active-low reset
//   clear               pulse; starts the zeroing sweep (sampled only in idle)
//   in_valid / in_ready triplet handshake (in_ready is combinational)
//   idx_a/b/c           atom indices for A, B (vertex), C
//   fa*/fb*/fc*         signed Q16.16 force components for each atom
//   rd_en / rd_idx      read request
//   rd_fx/fy/fz         read data, valid the cycle after rd_en
//   rd_valid            read data valid
//   busy                RMW sequence or clear sweep in progress
//   sat_flag            sticky: an accumulation saturated
// -----------------------------------------------------------------------------
module angle_force_accumulator #(
   parameter int ATOM_ADDR_W = 6,
   parameter int DATA_W      = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clear,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [ATOM_ADDR_W-1:0] idx_a,
   input  logic [ATOM_ADDR_W-1:0] idx_b,
   input  logic [ATOM_ADDR_W-1:0] idx_c,
   input  logic [DATA_W-1:0]      fax,
   input  logic [DATA_W-1:0]      fay,
   input  logic [DATA_W-1:0]      faz,
   input  logic [DATA_W-1:0]      fbx,
   input  logic [DATA_W-1:0]      fby,
   input  logic [DATA_W-1:0]      fbz,
   input  logic [DATA_W-1:0]      fcx,
   input  logic [DATA_W-1:0]      fcy,
   input  logic [DATA_W-1:0]      fcz,
   input  logic                   rd_en,
   input  logic [ATOM_ADDR_W-1:0] rd_idx,
   output logic [DATA_W-1:0]      rd_fx,
   output logic [DATA_W-1:0]      rd_fy,
   output logic [DATA_W-1:0]      rd_fz,
   output logic                   rd_valid,
   output logic                   busy,
   output logic                   sat_flag
);

   localparam int N_ATOMS = 1 << ATOM_ADDR_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACC_A,
      S_ACC_B,
      S_ACC_C,
      S_CLEAR
   } state_t;

   state_t r_state;
   state_t w_state_next;

   // Force file: one packed {z, y, x} word per atom. Every entry must be
   // zeroed by the asynchronous reset, so it is built from flops.
   logic [2:0][DATA_W-1:0]   r_file [N_ATOMS];

   // Holding registers captured on accept
   logic [ATOM_ADDR_W-1:0]   r_idx_a, r_idx_b, r_idx_c;
   logic [2:0][DATA_W-1:0]   r_fa, r_fb, r_fc;

   logic [ATOM_ADDR_W-1:0]   r_clr_cnt;
   logic                     r_rd_valid;
   logic [2:0][DATA_W-1:0]   r_rd_data;

   // FSM decode
   logic                     w_accept;
   logic                     w_clr_start;
   logic                     w_rmw;
   logic                     w_wr_clr;
   logic                     w_wr_en;
   logic [ATOM_ADDR_W-1:0]   w_wr_idx;
   logic [2:0][DATA_W-1:0]   w_add;

   // Datapath
   logic [2:0][DATA_W-1:0]   w_old;
   logic [2:0][DATA_W-1:0]   w_new;
   logic [2:0][DATA_W-1:0]   w_wr_data;

   // -------------------------------------------------------------------------
   // FSM
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_clr_start  = 1'b0;
      w_rmw        = 1'b0;
      w_wr_clr     = 1'b0;
      w_wr_idx     = r_idx_a;
      w_add        = r_fa;
      case (r_state)
         S_IDLE: begin
            // clear wins over a simultaneous triplet; the triplet stays pending
            if (clear) begin
               w_clr_start  = 1'b1;
               w_state_next = S_CLEAR;
            end else if (in_valid) begin
               w_accept     = 1'b1;
               w_state_next = S_ACC_A;
            end
         end
         S_ACC_A: begin
            w_rmw        = 1'b1;
            w_wr_idx     = r_idx_a;
            w_add        = r_fa;
            w_state_next = S_ACC_B;
         end
         S_ACC_B: begin
            w_rmw        = 1'b1;
            w_wr_idx     = r_idx_b;
            w_add        = r_fb;
            w_state_next = S_ACC_C;
         end
         S_ACC_C: begin
            w_rmw        = 1'b1;
            w_wr_idx     = r_idx_c;
            w_add        = r_fc;
            w_state_next = S_IDLE;
         end
         S_CLEAR: begin
            w_wr_clr = 1'b1;
            w_wr_idx = r_clr_cnt;
            if (r_clr_cnt == {ATOM_ADDR_W{1'b1}}) begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   assign w_wr_en  = w_rmw | w_wr_clr;
   assign in_ready = (r_state == S_IDLE) && !clear;
   assign busy     = (r_state != S_IDLE);

   // -------------------------------------------------------------------------
   // Holding registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx_a <= '0;
         r_idx_b <= '0;
         r_idx_c <= '0;
         r_fa    <= '0;
         r_fb    <= '0;
         r_fc    <= '0;
      end else if (w_accept) begin
         r_idx_a <= idx_a;
         r_idx_b <= idx_b;
         r_idx_c <= idx_c;
         r_fa    <= {faz, fay, fax};
         r_fb    <= {fbz, fby, fbx};
         r_fc    <= {fcz, fcy, fcx};
      end
   end

   // Sweep counter wraps back to 0 on the last entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_clr_cnt <= '0;
      end else if (r_state == S_CLEAR) begin
         r_clr_cnt <= r_clr_cnt + ATOM_ADDR_W'(1);
      end
   end

   // -------------------------------------------------------------------------
   // Per-component adder
   // -------------------------------------------------------------------------
   assign w_old = r_file[w_wr_idx];

`ifdef FACC_SAT_EN
   logic [2:0] w_ovf;
   logic       r_sat_flag;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_comp
`ifdef FACC_SAT_EN
         logic [DATA_W:0] w_sum;
         // Sign-extend to DATA_W+1 bits; overflow shows as the top two bits
         // disagreeing, and the top bit tells which rail to clamp to.
         assign w_sum      = {w_old[gi][DATA_W-1], w_old[gi]}
                           + {w_add[gi][DATA_W-1], w_add[gi]};
         assign w_ovf[gi]  = w_sum[DATA_W] ^ w_sum[DATA_W-1];
         assign w_new[gi]  = !w_ovf[gi]     ? w_sum[DATA_W-1:0] :
                             w_sum[DATA_W]  ? {1'b1, {(DATA_W-1){1'b0}}} :
                                              {1'b0, {(DATA_W-1){1'b1}}};
`else
         assign w_new[gi]  = w_old[gi] + w_add[gi];
`endif
         assign w_wr_data[gi] = w_wr_clr ? '0 : w_new[gi];
      end
   endgenerate

`ifdef FACC_SAT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sat_flag <= 1'b0;
      end else if (w_clr_start) begin
         r_sat_flag <= 1'b0;
      end else if (w_rmw && (|w_ovf)) begin
         r_sat_flag <= 1'b1;
      end
   end
   assign sat_flag = r_sat_flag;
`else
   assign sat_flag = 1'b0;
`endif

   // -------------------------------------------------------------------------
   // Force file write
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_ATOMS; i++) begin
            r_file[i] <= '0;
         end
      end else if (w_wr_en) begin
         r_file[w_wr_idx] <= w_wr_data;
      end
   end

   // -------------------------------------------------------------------------
   // Read port: sampled from the file before this cycle's write lands, so a
   // read of the entry being updated returns the pre-write value.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
      end else begin
         r_rd_valid <= rd_en;
         if (rd_en) begin
            r_rd_data <= r_file[rd_idx];
         end
      end
   end

   assign rd_valid = r_rd_valid;
   assign rd_fx    = r_rd_data[0];
   assign rd_fy    = r_rd_data[1];
   assign rd_fz    = r_rd_data[2];

endmodule

// File: tb/tb_angle_force_accumulator.sv
// -----------------------------------------------------------------------------
// tb_angle_force_accumulator
//
// Self-checking bench for angle_force_accumulator. Keeps a plain array model
// of the force file, applies each accepted triplet to it atom by atom with
// integer arithmetic, and compares read-port data and status outputs.
// Honours FACC_SAT_EN the same way as the design build.
// -----------------------------------------------------------------------------
module tb_angle_force_accumulator;

   localparam int AW = 6;
   localparam int DW = 32;
   localparam int NA = 1 << AW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clear = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [AW-1:0] idx_a = '0, idx_b = '0, idx_c = '0;
   logic [DW-1:0] fax = '0, fay = '0, faz = '0;
   logic [DW-1:0] fbx = '0, fby = '0, fbz = '0;
   logic [DW-1:0] fcx = '0, fcy = '0, fcz = '0;
   logic          rd_en = 1'b0;
   logic [AW-1:0] rd_idx = '0;
   logic [DW-1:0] rd_fx, rd_fy, rd_fz;
   logic          rd_valid;
   logic          busy;
   logic          sat_flag;

   angle_force_accumulator #(.ATOM_ADDR_W(AW), .DATA_W(DW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (clear),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .idx_a    (idx_a),
      .idx_b    (idx_b),
      .idx_c    (idx_c),
      .fax      (fax), .fay (fay), .faz (faz),
      .fbx      (fbx), .fby (fby), .fbz (fbz),
      .fcx      (fcx), .fcy (fcy), .fcz (fcz),
      .rd_en    (rd_en),
      .rd_idx   (rd_idx),
      .rd_fx    (rd_fx),
      .rd_fy    (rd_fy),
      .rd_fz    (rd_fz),
      .rd_valid (rd_valid),
      .busy     (busy),
      .sat_flag (sat_flag)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model of the force file
   logic [DW-1:0] mdl [NA][3];
   logic          mdl_sat = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] ref_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
      longint s;
      s = longint'($signed(a)) + longint'($signed(b));
`ifdef FACC_SAT_EN
      if (s > 64'sd2147483647) begin
         mdl_sat = 1'b1;
         return 32'h7FFF_FFFF;
      end
      if (s < -64'sd2147483648) begin
         mdl_sat = 1'b1;
         return 32'h8000_0000;
      end
`endif
      return s[DW-1:0];
   endfunction

   task automatic model_zero();
      for (int i = 0; i < NA; i++)
         for (int k = 0; k < 3; k++)
            mdl[i][k] = '0;
   endtask

   // Atoms are updated in order A, B, C so aliasing follows from sequencing
   task automatic model_apply(input int a, input int b, input int c,
                              input logic [2:0][DW-1:0] fa,
                              input logic [2:0][DW-1:0] fb,
                              input logic [2:0][DW-1:0] fc);
      for (int k = 0; k < 3; k++) mdl[a][k] = ref_add(mdl[a][k], fa[k]);
      for (int k = 0; k < 3; k++) mdl[b][k] = ref_add(mdl[b][k], fb[k]);
      for (int k = 0; k < 3; k++) mdl[c][k] = ref_add(mdl[c][k], fc[k]);
   endtask

   task automatic drive(input int a, input int b, input int c,
                        input logic [2:0][DW-1:0] fa,
                        input logic [2:0][DW-1:0] fb,
                        input logic [2:0][DW-1:0] fc);
      idx_a = AW'(a); idx_b = AW'(b); idx_c = AW'(c);
      fax = fa[0]; fay = fa[1]; faz = fa[2];
      fbx = fb[0]; fby = fb[1]; fbz = fb[2];
      fcx = fc[0]; fcy = fc[1]; fcz = fc[2];
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (busy && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (busy) check("idle_timeout", 64'(busy), 64'd0);
   endtask

   // Called at a negedge; returns at a negedge with the DUT idle
   task automatic send(input int a, input int b, input int c,
                       input logic [2:0][DW-1:0] fa,
                       input logic [2:0][DW-1:0] fb,
                       input logic [2:0][DW-1:0] fc);
      int k;
      drive(a, b, c, fa, fb, fc);
      in_valid = 1'b1;
      k = 0;
      while (!in_ready && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      model_apply(a, b, c, fa, fb, fc);
      wait_idle();
      check("sat_flag", 64'(sat_flag), 64'(mdl_sat));
      $display("triplet a=%0d b=%0d c=%0d fa=%h fb=%h fc=%h", a, b, c, fa, fb, fc);
   endtask

   task automatic read_chk(input int idx);
      rd_en  = 1'b1;
      rd_idx = AW'(idx);
      @(negedge clk);
      rd_en  = 1'b0;
      check("rd_valid", 64'(rd_valid), 64'd1);
      check("rd_fx", 64'(rd_fx), 64'(mdl[idx][0]));
      check("rd_fy", 64'(rd_fy), 64'(mdl[idx][1]));
      check("rd_fz", 64'(rd_fz), 64'(mdl[idx][2]));
   endtask

   function automatic logic [DW-1:0] rnd_force();
      logic [DW-1:0] v;
      if ($urandom_range(0, 7) == 0) begin
         v = $urandom;
      end else begin
         v = $urandom;
         v = {{(DW-21){v[20]}}, v[20:0]};
      end
      return v;
   endfunction

   logic [2:0][DW-1:0] z3, fa, fb, fc;
   int nb, nr, n_acc;
   int t_acc [2];

   initial begin
      z3 = '0;
      model_zero();

      // ---------------- reset ----------------
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_sat", 64'(sat_flag), 64'd0);
      check("rst_rd_valid", 64'(rd_valid), 64'd0);
      check("rst_rd_fx", 64'(rd_fx), 64'd0);
      read_chk(5);
      @(negedge clk);
      check("rd_valid_drop", 64'(rd_valid), 64'd0);

      // ---------------- single triplet, busy timing, read-during-write ----------------
      fa = '0; fa[0] = 32'h0001_0000;
      fb = '0; fb[0] = 32'hFFFE_0000;
      fc = '0; fc[0] = 32'h0001_0000;
      drive(1, 2, 3, fa, fb, fc);
      in_valid = 1'b1;
      #1 check("t1_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      nb = 0; nr = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 0) in_valid = 1'b0;
         if (busy) nb++;
         if (!in_ready) nr++;
         if (i == 1) begin
            // atom 1 was written in the same cycle it was read
            check("rd_prewrite_valid", 64'(rd_valid), 64'd1);
            check("rd_prewrite_fx", 64'(rd_fx), 64'd0);
            rd_en = 1'b0;
         end
         if (i == 2) check("rd_hold_fx", 64'(rd_fx), 64'd0);
         if (i == 0) begin
            rd_en = 1'b1;
            rd_idx = AW'(1);
         end
      end
      model_apply(1, 2, 3, fa, fb, fc);
      $display("triplet a=1 b=2 c=3 fa=%h fb=%h fc=%h", fa, fb, fc);
      check("t1_busy_cycles", 64'(nb), 64'd3);
      check("t1_notready_cycles", 64'(nr), 64'd3);
      read_chk(1);
      check("t1_atom1_x", 64'(rd_fx), 64'h0001_0000);
      read_chk(2);
      check("t1_atom2_x", 64'(rd_fx), 64'hFFFE_0000);
      read_chk(3);
      check("t1_atom3_x", 64'(rd_fx), 64'h0001_0000);

      // ---------------- aliasing a == c ----------------
      fa = '0; fa[1] = 32'h0000_8000;
      fc = '0; fc[1] = 32'h0000_8000;
      send(4, 5, 4, fa, z3, fc);
      read_chk(4);
      check("alias_atom4_y", 64'(rd_fy), 64'h0001_0000);

      // ---------------- back-to-back with in_valid held ----------------
      fa = {32'h0000_0001, 32'hFFFF_0000, 32'h0003_0000};
      fb = {32'h0000_0010, 32'h0000_4000, 32'hFFFF_8000};
      fc = {32'h0100_0000, 32'h0000_0000, 32'h0000_0002};
      drive(10, 11, 12, fa, fb, fc);
      in_valid = 1'b1;
      n_acc = 0;
      for (int k = 0; k < 40 && n_acc < 2; k++) begin
         if (in_ready) begin
            t_acc[n_acc] = cyc;
            n_acc++;
            model_apply(10, 11, 12, fa, fb, fc);
            $display("triplet a=10 b=11 c=12 fa=%h fb=%h fc=%h", fa, fb, fc);
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("b2b_accepts", 64'(n_acc), 64'd2);
      check("b2b_spacing", 64'(t_acc[1] - t_acc[0]), 64'd4);
      wait_idle();
      read_chk(10);
      check("b2b_atom10_x", 64'(rd_fx), 64'h0006_0000);
      read_chk(11);
      read_chk(12);

      // ---------------- overflow on atom 7 ----------------
      fa = '0; fa[0] = 32'h7FFF_0000;
      send(7, 8, 9, fa, z3, z3);
      fa = '0; fa[0] = 32'h0002_0000;
      send(7, 8, 9, fa, z3, z3);
      read_chk(7);
`ifdef FACC_SAT_EN
      check("ovf_atom7_x", 64'(rd_fx), 64'h7FFF_FFFF);
      check("ovf_sat_flag", 64'(sat_flag), 64'd1);
`else
      check("ovf_atom7_x", 64'(rd_fx), 64'h8001_0000);
      check("ovf_sat_flag", 64'(sat_flag), 64'd0);
`endif

      // ---------------- clear together with in_valid ----------------
      fa = {32'h0, 32'h0, 32'h0000_1234};
      fb = {32'h0, 32'h0005_0000, 32'h0};
      fc = {32'hFFFF_FFFF, 32'h0, 32'h0};
      drive(20, 21, 22, fa, fb, fc);
      clear    = 1'b1;
      in_valid = 1'b1;
      #1 check("clr_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      @(negedge clk);
      clear = 1'b0;
      check("clr_sat_cleared", 64'(sat_flag), 64'd0);
      nb = 0;
      while (busy && nb < 200) begin
         nb++;
         @(negedge clk);
      end
      check("clr_busy_cycles", 64'(nb), 64'(NA));
      model_zero();
      mdl_sat = 1'b0;
      check("clr_accept_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      model_apply(20, 21, 22, fa, fb, fc);
      $display("triplet a=20 b=21 c=22 fa=%h fb=%h fc=%h", fa, fb, fc);
      wait_idle();
      for (int i = 0; i < NA; i++) read_chk(i);

      // ---------------- clear ignored while busy ----------------
      fa = {32'h0, 32'h0, 32'h0001_0000};
      drive(30, 31, 32, fa, fa, fa);
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      model_apply(30, 31, 32, fa, fa, fa);
      wait_idle();
      check("clr_ignored_idle", 64'(busy), 64'd0);
      read_chk(30);

      // ---------------- randomized triplets ----------------
      for (int t = 0; t < 40; t++) begin
         int a, b, c;
         a = $urandom_range(0, NA - 1);
         b = ($urandom_range(0, 3) == 0) ? a : $urandom_range(0, NA - 1);
         c = ($urandom_range(0, 3) == 0) ? a : $urandom_range(0, NA - 1);
         for (int k = 0; k < 3; k++) begin
            fa[k] = rnd_force();
            fb[k] = rnd_force();
            fc[k] = rnd_force();
         end
         send(a, b, c, fa, fb, fc);
         read_chk(c);
         read_chk($urandom_range(0, NA - 1));
      end
      for (int i = 0; i < NA; i++) read_chk(i);

      // ---------------- reset in the middle of an RMW ----------------
      fa = {32'h0, 32'h0, 32'h0004_0000};
      drive(40, 41, 42, fa, fa, fa);
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check("midrst_busy", 64'(busy), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_zero();
      mdl_sat = 1'b0;
      @(negedge clk);
      check("midrst_sat", 64'(sat_flag), 64'd0);
      read_chk(40);
      read_chk(41);
      read_chk(42);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
